// File: rtl/e_scale_defs_pkg.sv
// Shared definitions for the E-scale loader: widths, per-mode beat plan, state encoding.
package e_scale_defs;

  localparam int WORD_W   = 512;
  localparam int SETS_NUM = 64;
  localparam int IDX_W    = 8;

  // Beat counts are kept as "last beat index" so they fit the 2-bit counter.
  localparam logic [1:0] TAIL_LAST_M0 = 2'd1;  // 2 tail beats
  localparam logic [1:0] TAIL_LAST_M1 = 2'd3;  // 4 tail beats
  localparam logic [1:0] RANK_LAST_M0 = 2'd0;  // 1 rank beat
  localparam logic [1:0] RANK_LAST_M1 = 2'd1;  // 2 rank beats

  localparam logic [IDX_W-1:0] TAIL_SIZE_M0 = 8'd32;
  localparam logic [IDX_W-1:0] TAIL_SIZE_M1 = 8'd16;
  localparam logic [IDX_W-1:0] RANK_SIZE_M0 = 8'd64;
  localparam logic [IDX_W-1:0] RANK_SIZE_M1 = 8'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAIL = 2'd1,
    ST_RANK = 2'd2
  } state_e;

endpackage

// File: rtl/e_scale_loader.sv
// E-scale loader: turns a start command plus a word stream into tail/rank
// register-bank writes, one registered write per accepted word.
module e_scale_loader
  import e_scale_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              tail_set,
  output logic [WORD_W-1:0] tail_word,
  output logic [IDX_W-1:0]  tail_reg_start,
  output logic [IDX_W-1:0]  tail_reg_size,
  output logic              rank_set,
  output logic [WORD_W-1:0] rank_word,
  output logic [IDX_W-1:0]  rank_reg_start,
  output logic [IDX_W-1:0]  rank_reg_size,
  output logic              busy,
  output logic              done
);

  state_e           state, state_nxt;
  logic             mode_q;
  logic [1:0]       beat;
  logic             acc;
  logic             last_beat;
  logic             final_acc;
  logic [1:0]       cur_last;
  logic [IDX_W-1:0] cur_size;
  logic [IDX_W-1:0] cur_start;

  // State register, with the mode latched on the accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) mode_q <= mode;
    end
  end

  // Next-state: advance only when the last beat of a phase is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)            state_nxt = ST_TAIL;
      ST_TAIL: if (acc && last_beat) state_nxt = ST_RANK;
      ST_RANK: if (acc && last_beat) state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Output/decode: handshake and per-phase beat plan from the latched mode.
  always_comb begin
    word_ready = (state == ST_TAIL) || (state == ST_RANK);
    acc        = word_valid && word_ready;
    cur_last   = 2'd0;
    cur_size   = '0;
    if (state == ST_TAIL) begin
      cur_last = mode_q ? TAIL_LAST_M1 : TAIL_LAST_M0;
      cur_size = mode_q ? TAIL_SIZE_M1 : TAIL_SIZE_M0;
    end else if (state == ST_RANK) begin
      cur_last = mode_q ? RANK_LAST_M1 : RANK_LAST_M0;
      cur_size = mode_q ? RANK_SIZE_M1 : RANK_SIZE_M0;
    end
    last_beat = (beat == cur_last);
    final_acc = acc && last_beat && (state == ST_RANK);
    // Registers are 1-based and packed contiguously: 1 + beat*size, 8-bit wrap.
    cur_start = IDX_W'(1) + ({{(IDX_W-2){1'b0}}, beat} * cur_size);
  end

  // Beat counter: restarts on every phase change, steps on accept.
  always_ff @(posedge clk) begin
    if (!reset)                  beat <= 2'd0;
    else if (state_nxt != state) beat <= 2'd0;
    else if (acc)                beat <= beat + 2'd1;
  end

  // Output stage: one-cycle set pulses; data/start/size hold between pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tail_set       <= 1'b0;
      tail_word      <= '0;
      tail_reg_start <= '0;
      tail_reg_size  <= '0;
      rank_set       <= 1'b0;
      rank_word      <= '0;
      rank_reg_start <= '0;
      rank_reg_size  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      tail_set <= acc && (state == ST_TAIL);
      rank_set <= acc && (state == ST_RANK);
      if (acc && state == ST_TAIL) begin
        tail_word      <= word_data;
        tail_reg_start <= cur_start;
        tail_reg_size  <= cur_size;
      end
      if (acc && state == ST_RANK) begin
        rank_word      <= word_data;
        rank_reg_start <= cur_start;
        rank_reg_size  <= cur_size;
      end
      // busy covers the final rank pulse even though the FSM is IDLE by then.
      busy <= (state_nxt != ST_IDLE) || final_acc;
      done <= final_acc;
    end
  end

endmodule

// File: tb/tb_e_scale_loader.sv
// Scoreboard bench for e_scale_loader: the driver queues expected writes,
// a negedge monitor pops and compares every set pulse.
module tb_e_scale_loader;
  import e_scale_defs::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [WORD_W-1:0] word_data = '0;
  logic              tail_set, rank_set, busy, done;
  logic [WORD_W-1:0] tail_word, rank_word;
  logic [IDX_W-1:0]  tail_reg_start, tail_reg_size, rank_reg_start, rank_reg_size;

  e_scale_loader dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .tail_set(tail_set), .tail_word(tail_word),
    .tail_reg_start(tail_reg_start), .tail_reg_size(tail_reg_size),
    .rank_set(rank_set), .rank_word(rank_word),
    .rank_reg_start(rank_reg_start), .rank_reg_size(rank_reg_size),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rank;
    logic [WORD_W-1:0] word;
    logic [7:0]        rstart;
    logic [7:0]        rsize;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tail_cov[64];
  int   rank_cov[64];

  task automatic chk(input string name, input logic ok, input string detail);
    n_checks++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: every set pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tail_set === 1'b1 || rank_set === 1'b1) begin
      logic              is_rank;
      logic [WORD_W-1:0] w;
      logic [7:0]        s, z;
      exp_t              e;
      is_rank = rank_set;
      w = is_rank ? rank_word : tail_word;
      s = is_rank ? rank_reg_start : tail_reg_start;
      z = is_rank ? rank_reg_size : tail_reg_size;
      for (int r = 0; r < int'(z); r++)
        if (int'(s) - 1 + r < 64) begin
          if (is_rank) rank_cov[int'(s) - 1 + r]++;
          else         tail_cov[int'(s) - 1 + r]++;
        end
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1'b0, $sformatf("got tail=%0b rank=%0b start=%0d, none expected",
            tail_set, rank_set, s));
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", (tail_set && rank_set) ? 1'b0 : (is_rank == e.rank),
            $sformatf("got tail=%0b rank=%0b, need rank=%0b", tail_set, rank_set, e.rank));
        chk("pulse_start", s == e.rstart, $sformatf("got %0d need %0d", s, e.rstart));
        chk("pulse_size", z == e.rsize, $sformatf("got %0d need %0d", z, e.rsize));
        chk("pulse_word", w == e.word, $sformatf("got %h need %h", w[31:0], e.word[31:0]));
        chk("pulse_done", done == e.done, $sformatf("got %0b need %0b", done, e.done));
        chk("pulse_busy", busy, $sformatf("got %0b need 1", busy));
      end
    end else if (done === 1'b1) begin
      chk("stray_done", 1'b0, "got done=1 without rank_set, need 0");
    end
  end

  function automatic logic [WORD_W-1:0] mk_word(input int k);
    return {16{32'hA500_0000 + k}};
  endfunction

  // Hand-computed beat plans.
  function automatic logic [7:0] t_start(input logic m, input int i);
    if (m) case (i) 0: return 8'd1; 1: return 8'd17; 2: return 8'd33; default: return 8'd49; endcase
    else   case (i) 0: return 8'd1; default: return 8'd33; endcase
  endfunction
  function automatic logic [7:0] r_start(input int i);
    return (i == 0) ? 8'd1 : 8'd33;
  endfunction

  task automatic push_exp(input logic rk, input logic [WORD_W-1:0] w, input logic [7:0] s,
                          input logic [7:0] z, input logic d);
    exp_t e;
    e.rank = rk; e.word = w; e.rstart = s; e.rsize = z; e.done = d;
    exp_q.push_back(e);
  endtask

  // Present a word and hold valid until it is accepted (bounded wait).
  task automatic send_word(input logic [WORD_W-1:0] w);
    bit ok = 0;
    word_valid = 1'b1;
    word_data  = w;
    for (int c = 0; c < 20; c++) begin
      if (word_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", ok, "got no accept within 20 cycles, need accept");
    if (ok) chk("latency", tail_set | rank_set, "got no set pulse 1 cycle after accept, need 1");
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input logic m, input int base, input int gap, input bit issue_start,
                          input bit poke_start, input bit chain, input logic chain_mode);
    int nt, nr;
    nt = m ? 4 : 2;
    nr = m ? 2 : 1;
    if (issue_start) do_start(m);
    for (int i = 0; i < nt; i++) begin
      push_exp(1'b0, mk_word(base + i), t_start(m, i), m ? 8'd16 : 8'd32, 1'b0);
      send_word(mk_word(base + i));
      if (poke_start && i == 0) begin
        start = 1'b1; mode = ~m;
      end
      if (gap > 0) begin
        word_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; start = 1'b0; end
      end
      start = 1'b0;
    end
    for (int i = 0; i < nr; i++) begin
      push_exp(1'b1, mk_word(base + nt + i), r_start(i), m ? 8'd32 : 8'd64, i == nr - 1);
      send_word(mk_word(base + nt + i));
      if (gap > 0 && i != nr - 1) begin
        word_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    word_valid = 1'b0;
    if (chain) begin
      // This is the done cycle: a start here must launch the next load.
      chk("done_cycle", done, $sformatf("got done=%0b need 1", done));
      do_start(chain_mode);
      chk("busy_chain", busy, $sformatf("got busy=%0b need 1", busy));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    foreach (tail_cov[i]) begin tail_cov[i] = 0; rank_cov[i] = 0; end
    idle(3);
    reset = 1'b1;
    idle(1);
    chk("reset_state", {tail_set, rank_set, busy, done, word_ready} == 5'b0 &&
        tail_reg_start == 0 && rank_reg_size == 0 && tail_word == '0,
        $sformatf("got ts=%0b rs=%0b busy=%0b done=%0b rdy=%0b, need all 0",
                  tail_set, rank_set, busy, done, word_ready));

    // 1: reset mid-load abandons it
    do_start(1'b1);
    push_exp(1'b0, mk_word(100), 8'd1, 8'd16, 1'b0);
    send_word(mk_word(100));
    push_exp(1'b0, mk_word(101), 8'd17, 8'd16, 1'b0);
    send_word(mk_word(101));
    reset = 1'b0;
    idle(1);
    chk("reset_mid", {tail_set, rank_set, busy, done, word_ready} == 5'b0 &&
        tail_reg_start == 0 && tail_reg_size == 0 && tail_word == '0,
        $sformatf("got ts=%0b rs=%0b busy=%0b done=%0b rdy=%0b start=%0d, need all 0",
                  tail_set, rank_set, busy, done, word_ready, tail_reg_start));
    word_valid = 1'b0;
    reset = 1'b1;
    idle(3);
    run_load(1'b1, 200, 0, 1, 0, 0, 1'b0);
    idle(3);

    // 2: mode0 back-to-back
    run_load(1'b0, 300, 0, 1, 0, 0, 1'b0);
    idle(2);
    chk("idle_ready", word_ready == 1'b0, $sformatf("got %0b need 0", word_ready));
    chk("idle_busy", busy == 1'b0, $sformatf("got %0b need 0", busy));

    // 3 + 6: mode1 back-to-back with bank coverage
    foreach (tail_cov[i]) begin tail_cov[i] = 0; rank_cov[i] = 0; end
    run_load(1'b1, 400, 0, 1, 0, 0, 1'b0);
    idle(2);
    for (int row = 1; row <= 16; row++) begin
      bit ok = 1;
      for (int k = 0; k < 4; k++) begin
        if (tail_cov[(row - 1) * 4 + k] != 1) ok = 0;
        if (rank_cov[(row - 1) * 4 + k] != 1) ok = 0;
      end
      chk($sformatf("bank_row%0d", row), ok,
          $sformatf("got tail/rank write count %0d/%0d for first reg, need 1/1",
                    tail_cov[(row - 1) * 4], rank_cov[(row - 1) * 4]));
    end

    // 4: stalls
    chk("idle_ready2", word_ready == 1'b0, $sformatf("got %0b need 0", word_ready));
    run_load(1'b1, 500, 2, 1, 0, 0, 1'b0);
    idle(2);

    // 5: start while busy ignored, start in done cycle chains a mode0 load
    run_load(1'b1, 600, 0, 1, 1, 1, 1'b0);
    run_load(1'b0, 700, 0, 0, 0, 0, 1'b0);
    idle(4);

    chk("queue_drained", exp_q.size() == 0, $sformatf("got %0d pending need 0", exp_q.size()));
    chk("end_idle", {busy, done, word_ready} == 3'b0,
        $sformatf("got busy=%0b done=%0b rdy=%0b need 0", busy, done, word_ready));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
